qpu_exu_evt_sched: RTL and testbench
====================================

Name: qpu_exu_evt_sched

Overview:
Timing-queue scheduler behind the execution-unit time and event write-back interfaces.
- Holds the current timing label, updated by QWAIT-style time write-backs.
- Buffers each quantum event (event wire data plus qubit operand mask) tagged with the timing label in force when it was accepted.
- Releases each event to the quantum event output on the exact cycle the free-running system timer reaches its tag.
- Sits between the ALU write-back (time/event ports) and the qubit control-signal generators.

Parameters:
TIME_W, 32, timer and timing-label width (matches QPU_TIME_WIDTH)
EDATA_W, 32, event wire data width (matches QPU_EVENT_WIRE_WIDTH)
EVT_NUM, 8, operand mask width (matches QPU_EVENT_NUM)
DEPTH, 8, queue entries, power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
run  in  1  system timer counts while high
clr  in  1  synchronous clear: timer, timing label and queue to 0; overrides all other inputs that cycle
t_i_valid  in  1  timing-label write valid
t_i_ready  out  1  always 1
t_i_data  in  TIME_W  new absolute timing label
e_i_valid  in  1  event push valid
e_i_ready  out  1  queue can accept
e_i_data  in  EDATA_W  event wire data
e_i_oprand  in  EVT_NUM  qubit operand mask
evt_o_valid  out  1  one-cycle event issue strobe, no back-pressure
evt_o_data  out  EDATA_W  issued event data
evt_o_oprand  out  EVT_NUM  issued operand mask
evt_o_time  out  TIME_W  tag of issued event
late_err  out  1  sticky: an event issued after its tag
sys_time  out  TIME_W  system timer value
q_cnt  out  clog2(DEPTH)+1  queue occupancy
q_empty  out  1  q_cnt==0

Behaviour:
- Reset (rst high, async): sys_time=0, label=0, q_cnt=0, q_empty=1, evt_o_valid=0, evt_o_data/oprand/time=0, late_err=0, rd/wr pointers=0.
- Timer: sys_time += 1 per cycle while run=1, else holds. Wraps modulo 2^TIME_W.
- Label:
  - t_i_valid=1 loads label<=t_i_data next edge.
  - Push in the same cycle as t_i_valid tags the event with t_i_data (bypass), not the old label.
- Push:
  - Occurs when e_i_valid & e_i_ready.
  - e_i_ready = (q_cnt != DEPTH), derived from registered state only; no combinational path from the pop.
  - Entry = {tag, data, oprand} written at wr_ptr; wr_ptr wraps at DEPTH.
- Due test on the head entry:
  - diff = sys_time - head.tag (mod 2^TIME_W).
  - due = ~q_empty & (diff[TIME_W-1]==0). The tag counts as reached or past when diff is in [0, 2^(TIME_W-1)).
  - late = due & (diff != 0).
- Pop/issue:
  - When due, the head pops that cycle.
  - Next edge: evt_o_valid=1 and evt_o_* = head fields. Latency is 1 cycle from sys_time==tag to the strobe.
  - At most one pop per cycle. Further entries with equal tags issue on successive cycles and are flagged late.
  - When not due: evt_o_valid=0; evt_o_data/oprand/time hold their last values.
- late_err: set on any pop with late=1; cleared only by rst or clr.
- Simultaneous push and pop: q_cnt unchanged. Push into a full queue is impossible because e_i_ready=0. Pop when empty is impossible because due requires ~q_empty.
- Push into an empty queue with tag == sys_time: the entry becomes due the next cycle (the registered queue is not bypassed), so it issues late by 1 cycle and sets late_err. Software schedules at least 2 cycles ahead.
- clr mid-operation:
  - Discards queued entries and drops any pending pop.
  - evt_o_valid=0 next cycle.
  - A push or t_i write in the clr cycle is ignored.
- run=0: the queue still accepts pushes. Entries already due still issue, since the due test is on the current sys_time.

Decomposition:
- Shared package/defines: TIME_W/EDATA_W/EVT_NUM mapped from the existing QPU_TIME_WIDTH, QPU_EVENT_WIRE_WIDTH and QPU_EVENT_NUM defines; entry field layout; queue depth define.
- One sub-module: qpu_evt_fifo (circular buffer with pointers, count, full/empty, registered storage).
- Label, timer, due/late logic and issue register stay in the top.

Test Plan:
1. Reset then run=1; t_i 10, push {data=0xA5, oprand=0x01} -> evt_o_valid exactly at the cycle after sys_time=10, evt_o_time=10, data=0xA5, late_err=0.
2. Same cycle t_i=20 and push -> entry tagged 20 (not the old label), issue after sys_time=20.
3. Push 8 entries with tags 30..37 while the timer is below 30 -> e_i_ready=0, q_cnt=8. 9th push stalls until the first pop at 30. Issues occur on 8 consecutive cycles, in order.
4. Two pushes with equal tag 50 -> first issues on time, second one cycle later, late_err=1 and stays high.
5. Wrap: preload sys_time near 2^TIME_W-3 (TIME_W=8: timer=253), tag=2 -> issues after the wrap at sys_time=2, not immediately.
6. 3 entries queued, clr pulse -> q_cnt=0, q_empty=1, sys_time=0, no evt_o_valid afterwards; async rst mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/qpu_exu_evt_sched_pkg.sv
// rtl/qpu_exu_evt_sched_pkg.sv - shared widths and entry layout for the event scheduler
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 32
`endif
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 32
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 8
`endif
`ifndef QPU_EVT_QDEPTH
`define QPU_EVT_QDEPTH 8
`endif

package qpu_exu_evt_sched_pkg;

  localparam int QPU_TIME_W   = `QPU_TIME_WIDTH;
  localparam int QPU_EDATA_W  = `QPU_EVENT_WIRE_WIDTH;
  localparam int QPU_EVT_N    = `QPU_EVENT_NUM;
  localparam int QPU_QDEPTH   = `QPU_EVT_QDEPTH;

  // Queue entry is packed as {tag, data, oprand}, tag in the MSBs.
  function automatic int evt_entry_w(input int tw, input int dw, input int nw);
    return tw + dw + nw;
  endfunction

endpackage

// File: rtl/qpu_evt_fifo.sv
// rtl/qpu_evt_fifo.sv - circular buffer holding tagged quantum events
module qpu_evt_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/qpu_exu_evt_sched.sv
// rtl/qpu_exu_evt_sched.sv - timing-queue scheduler releasing events when the timer reaches their tag
module qpu_exu_evt_sched
  import qpu_exu_evt_sched_pkg::*;
#(
  parameter int TIME_W  = QPU_TIME_W,
  parameter int EDATA_W = QPU_EDATA_W,
  parameter int EVT_NUM = QPU_EVT_N,
  parameter int DEPTH   = QPU_QDEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     clr,
  input  logic                     t_i_valid,
  output logic                     t_i_ready,
  input  logic [TIME_W-1:0]        t_i_data,
  input  logic                     e_i_valid,
  output logic                     e_i_ready,
  input  logic [EDATA_W-1:0]       e_i_data,
  input  logic [EVT_NUM-1:0]       e_i_oprand,
  output logic                     evt_o_valid,
  output logic [EDATA_W-1:0]       evt_o_data,
  output logic [EVT_NUM-1:0]       evt_o_oprand,
  output logic [TIME_W-1:0]        evt_o_time,
  output logic                     late_err,
  output logic [TIME_W-1:0]        sys_time,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     q_empty
);

  localparam int EW = evt_entry_w(TIME_W, EDATA_W, EVT_NUM);

  logic [TIME_W-1:0]  sys_time_q, label_q, push_tag, diff;
  logic [EW-1:0]      head, push_entry;
  logic [TIME_W-1:0]  head_tag;
  logic [EDATA_W-1:0] head_data;
  logic [EVT_NUM-1:0] head_oprand;
  logic               fifo_full, fifo_empty, push, pop, due, late;
  logic               evt_valid_q, late_err_q;
  logic [EDATA_W-1:0] evt_data_q;
  logic [EVT_NUM-1:0] evt_oprand_q;
  logic [TIME_W-1:0]  evt_time_q;

  // A label write in the same cycle as a push tags that push (bypass).
  assign push_tag   = t_i_valid ? t_i_data : label_q;
  assign push_entry = {push_tag, e_i_data, e_i_oprand};
  assign push       = e_i_valid & e_i_ready & ~clr;

  assign head_tag    = head[EW-1 -: TIME_W];
  assign head_data   = head[EVT_NUM +: EDATA_W];
  assign head_oprand = head[EVT_NUM-1:0];

  // Head is due once the modular distance from tag to timer lies in the lower half-range.
  assign diff = sys_time_q - head_tag;
  assign due  = ~fifo_empty & ~diff[TIME_W-1];
  assign late = due & (diff != '0);
  assign pop  = due & ~clr;

  qpu_evt_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .cnt_o   (q_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Free-running system timer and current timing label.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_time_q <= '0;
      label_q    <= '0;
    end else if (clr) begin
      sys_time_q <= '0;
      label_q    <= '0;
    end else begin
      if (run)       sys_time_q <= sys_time_q + 1'b1;
      if (t_i_valid) label_q    <= t_i_data;
    end
  end

  // Issue register: one-cycle strobe per pop, payload holds between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      evt_oprand_q <= '0;
      evt_time_q   <= '0;
      late_err_q   <= 1'b0;
    end else if (clr) begin
      evt_valid_q  <= 1'b0;
      late_err_q   <= 1'b0;
    end else begin
      evt_valid_q <= pop;
      if (pop) begin
        evt_data_q   <= head_data;
        evt_oprand_q <= head_oprand;
        evt_time_q   <= head_tag;
        if (late) late_err_q <= 1'b1;
      end
    end
  end

  assign t_i_ready    = 1'b1;
  assign e_i_ready    = ~fifo_full;
  assign q_empty      = fifo_empty;
  assign sys_time     = sys_time_q;
  assign evt_o_valid  = evt_valid_q;
  assign evt_o_data   = evt_data_q;
  assign evt_o_oprand = evt_oprand_q;
  assign evt_o_time   = evt_time_q;
  assign late_err     = late_err_q;

endmodule

// File: tb/tb_qpu_exu_evt_sched.sv
// tb/tb_qpu_exu_evt_sched.sv - directed self-checking bench for the event scheduler
module tb_qpu_exu_evt_sched;

  logic        clk = 1'b0;
  logic        rst, run, clr;
  logic        t_i_valid, t_i_ready;
  logic [7:0]  t_i_data;
  logic        e_i_valid, e_i_ready;
  logic [31:0] e_i_data;
  logic [7:0]  e_i_oprand;
  logic        evt_o_valid;
  logic [31:0] evt_o_data;
  logic [7:0]  evt_o_oprand;
  logic [7:0]  evt_o_time;
  logic        late_err;
  logic [7:0]  sys_time;
  logic [3:0]  q_cnt;
  logic        q_empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  lg_t [32];
  logic [31:0] lg_d [32];
  logic [7:0]  lg_o [32];
  logic [7:0]  lg_s [32];
  int          lg_n;
  logic [7:0]  acc_sys;

  qpu_exu_evt_sched #(.TIME_W(8), .EDATA_W(32), .EVT_NUM(8), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .clr          (clr),
    .t_i_valid    (t_i_valid),
    .t_i_ready    (t_i_ready),
    .t_i_data     (t_i_data),
    .e_i_valid    (e_i_valid),
    .e_i_ready    (e_i_ready),
    .e_i_data     (e_i_data),
    .e_i_oprand   (e_i_oprand),
    .evt_o_valid  (evt_o_valid),
    .evt_o_data   (evt_o_data),
    .evt_o_oprand (evt_o_oprand),
    .evt_o_time   (evt_o_time),
    .late_err     (late_err),
    .sys_time     (sys_time),
    .q_cnt        (q_cnt),
    .q_empty      (q_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and record any issued event together with the timer seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (evt_o_valid === 1'b1 && lg_n < 32) begin
      lg_t[lg_n] = evt_o_time;
      lg_d[lg_n] = evt_o_data;
      lg_o[lg_n] = evt_o_oprand;
      lg_s[lg_n] = sys_time;
      lg_n++;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clr = 1'b0;
    t_i_valid = 1'b0; t_i_data = '0;
    e_i_valid = 1'b0; e_i_data = '0; e_i_oprand = '0;
    lg_n = 0;
    acc_sys = 8'hFF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sys_time", sys_time, 0);
    chk("rst_q_cnt", q_cnt, 0);
    chk("rst_q_empty", q_empty, 1);
    chk("rst_evt_valid", evt_o_valid, 0);
    chk("rst_evt_data", evt_o_data, 0);
    chk("rst_late_err", late_err, 0);
    chk("rst_e_ready", e_i_ready, 1);
    chk("rst_t_ready", t_i_ready, 1);
    rst = 1'b0;

    // 1: label 10 then push, issue right after sys_time reaches 10
    run = 1'b1;
    t_i_valid = 1'b1; t_i_data = 8'd10;
    tick();
    t_i_valid = 1'b0;
    e_i_valid = 1'b1; e_i_data = 32'hA5; e_i_oprand = 8'h01;
    tick();
    e_i_valid = 1'b0;
    chk("t1_q_cnt", q_cnt, 1);
    chk("t1_q_empty", q_empty, 0);
    lg_n = 0;
    repeat (12) tick();
    chk("t1_n_issue", lg_n, 1);
    chk("t1_time", lg_t[0], 10);
    chk("t1_sys_at_issue", lg_s[0], 11);
    chk("t1_data", lg_d[0], 32'hA5);
    chk("t1_oprand", lg_o[0], 8'h01);
    chk("t1_late_err", late_err, 0);

    // 2: label write and push together; push uses the new label
    t_i_valid = 1'b1; t_i_data = 8'd20;
    e_i_valid = 1'b1; e_i_data = 32'hB6; e_i_oprand = 8'h02;
    lg_n = 0;
    tick();
    t_i_valid = 1'b0; e_i_valid = 1'b0;
    repeat (10) tick();
    chk("t2_n_issue", lg_n, 1);
    chk("t2_time", lg_t[0], 20);
    chk("t2_sys_at_issue", lg_s[0], 21);
    chk("t2_data", lg_d[0], 32'hB6);

    // 3: fill with tags 30..37 while the timer is held, then a stalled ninth push
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t_i_valid = 1'b1; t_i_data = 8'(30 + i);
      e_i_valid = 1'b1; e_i_data = 32'(8'h30 + i); e_i_oprand = 8'(1 << i);
      tick();
    end
    t_i_valid = 1'b0; e_i_valid = 1'b0;
    chk("t3_full_cnt", q_cnt, 8);
    chk("t3_full_ready", e_i_ready, 0);
    chk("t3_timer_held", sys_time, 25);
    lg_n = 0;
    t_i_valid = 1'b1; t_i_data = 8'd38;
    e_i_valid = 1'b1; e_i_data = 32'h38; e_i_oprand = 8'hFF;
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (e_i_ready === 1'b1) begin
        acc_sys = sys_time;
        tick();
        break;
      end
      tick();
    end
    t_i_valid = 1'b0; e_i_valid = 1'b0;
    chk("t3_ninth_accept_sys", acc_sys, 31);
    repeat (8) tick();
    chk("t3_n_issue", lg_n, 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3_time_%0d", i), lg_t[i], 64'(30 + i));
      chk($sformatf("t3_sys_%0d", i), lg_s[i], 64'(31 + i));
      chk($sformatf("t3_data_%0d", i), lg_d[i], 64'(8'h30 + i));
      chk($sformatf("t3_oprand_%0d", i), lg_o[i], (i < 8) ? 64'(1 << i) : 64'hFF);
    end
    chk("t3_late_err", late_err, 0);
    chk("t3_q_empty", q_empty, 1);

    // 4: two events sharing tag 50; second one is late
    t_i_valid = 1'b1; t_i_data = 8'd50;
    e_i_valid = 1'b1; e_i_data = 32'h51; e_i_oprand = 8'h10;
    tick();
    t_i_valid = 1'b0;
    e_i_data = 32'h52; e_i_oprand = 8'h20;
    tick();
    e_i_valid = 1'b0;
    lg_n = 0;
    repeat (13) tick();
    chk("t4_n_issue", lg_n, 2);
    chk("t4_time0", lg_t[0], 50);
    chk("t4_sys0", lg_s[0], 51);
    chk("t4_data0", lg_d[0], 32'h51);
    chk("t4_time1", lg_t[1], 50);
    chk("t4_sys1", lg_s[1], 52);
    chk("t4_data1", lg_d[1], 32'h52);
    chk("t4_late_err", late_err, 1);
    repeat (3) tick();
    chk("t4_late_sticky", late_err, 1);

    // clr zeroes timer and late_err
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sys_time", sys_time, 0);
    chk("clr_late_err", late_err, 0);

    // 5: wrap, tag 2 pushed at timer 253 must wait for the wrap
    repeat (253) tick();
    chk("t5_sys_preload", sys_time, 253);
    t_i_valid = 1'b1; t_i_data = 8'd2;
    e_i_valid = 1'b1; e_i_data = 32'h77; e_i_oprand = 8'h80;
    lg_n = 0;
    tick();
    t_i_valid = 1'b0; e_i_valid = 1'b0;
    tick();
    chk("t5_no_early_issue", lg_n, 0);
    repeat (8) tick();
    chk("t5_n_issue", lg_n, 1);
    chk("t5_time", lg_t[0], 2);
    chk("t5_sys_at_issue", lg_s[0], 3);
    chk("t5_late_err", late_err, 0);

    // 6: three queued entries discarded by clr; push and label write in the clr cycle ignored
    t_i_valid = 1'b1; t_i_data = 8'd100;
    e_i_valid = 1'b1; e_i_data = 32'hC0; e_i_oprand = 8'h03;
    repeat (3) tick();
    chk("t6_q_cnt", q_cnt, 3);
    clr = 1'b1;
    t_i_data = 8'd5; e_i_data = 32'hEE;
    tick();
    clr = 1'b0; t_i_valid = 1'b0; e_i_valid = 1'b0;
    chk("t6_clr_q_cnt", q_cnt, 0);
    chk("t6_clr_q_empty", q_empty, 1);
    chk("t6_clr_sys", sys_time, 0);
    chk("t6_clr_evt_valid", evt_o_valid, 0);
    lg_n = 0;
    repeat (10) tick();
    chk("t6_no_issue_after_clr", lg_n, 0);
    chk("t6_q_cnt_after", q_cnt, 0);
    chk("t6_evt_data_held", evt_o_data, 32'h77);

    // async reset mid-cycle clears everything immediately
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sys_time", sys_time, 0);
    chk("arst_evt_data", evt_o_data, 0);
    chk("arst_evt_oprand", evt_o_oprand, 0);
    chk("arst_evt_time", evt_o_time, 0);
    chk("arst_evt_valid", evt_o_valid, 0);
    chk("arst_q_cnt", q_cnt, 0);
    chk("arst_q_empty", q_empty, 1);
    chk("arst_late_err", late_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
